// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-PC sequencer with jump/branch redirect, stall, range-based
//               end-of-program detection, misalignment fault and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter int unsigned       PROG_WORDS  = 256,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              ext_halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              pc_valid_o,
  output logic              eof_o,
  output logic              fault_o,
  output logic [CNT_W-1:0]  retired_count_o
);

  localparam logic [ADDR_W-1:0] C_STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  // Byte distance from RESET_VEC to the last valid PC.
  localparam logic [ADDR_W-1:0] C_SPAN       = ADDR_W'((PROG_WORDS - 1) * INSTR_BYTES);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_offset;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_retire;

  // Offset from RESET_VEC wraps modulo 2^ADDR_W, so targets below RESET_VEC
  // (including pc_plus wrap-around) land above C_SPAN and count as out of range.
  always_comb begin
    w_pc_plus      = pc_q + C_STEP;
    w_next_pc      = jump_i         ? jump_target_i   :
                     branch_taken_i ? branch_target_i : w_pc_plus;
    w_offset       = w_next_pc - RESET_VEC;
    w_misaligned   = |(w_next_pc & C_ALIGN_MASK);
    w_out_of_range = (w_offset > C_SPAN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    w_retire = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ext_halt_i) begin
          state_d = S_DRAIN;
        end else if (!stall_i) begin
          w_retire = 1'b1;
          if (w_misaligned) begin
            fault_d = 1'b1;
            state_d = S_DRAIN;
          end else if (w_out_of_range) begin
            state_d = S_DRAIN;
          end else begin
            pc_d = w_next_pc;
          end
        end
      end
      S_DRAIN: state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    cnt_d = (w_retire && (cnt_q != '1)) ? cnt_q + C_CNT_ONE : cnt_q;
  end

  always_comb begin
    pc_valid_o = 1'b0;
    eof_o      = 1'b0;
    case (state_q)
      S_RUN:   pc_valid_o = 1'b1;
      S_HALT:  eof_o      = 1'b1;
      default: begin
        pc_valid_o = 1'b0;
        eof_o      = 1'b0;
      end
    endcase
  end

  assign pc_o            = pc_q;
  assign pc_plus_o       = w_pc_plus;
  assign fault_o         = fault_q;
  assign retired_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed table-driven bench for pc_sequencer plus short
//               sequences on small-program and narrow-counter instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          br;
    logic [31:0] bt;
    bit          jmp;
    logic [31:0] jt;
    bit          halt;
    logic [31:0] exp_pc;
    bit          exp_valid;
    bit          exp_eof;
    bit          exp_fault;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic        halt;

  logic [31:0] pc_a, pcp_a, cnt_a;
  logic        v_a, e_a, f_a;
  logic [31:0] pc_b, pcp_b, cnt_b;
  logic        v_b, e_b, f_b;
  logic [31:0] pc_c, pcp_c, cnt_c;
  logic        v_c, e_c, f_c;
  logic [31:0] pc_d, pcp_d;
  logic [1:0]  cnt_d;
  logic        v_d, e_d, f_d;

  int n_run  = 0;
  int n_fail = 0;

  vec_t vq[$];

  int b_pc [6] = '{4, 8, 12, 12, 12, 12};
  int b_cnt[6] = '{1, 2, 3, 4, 4, 4};
  int b_v  [6] = '{1, 1, 1, 0, 0, 0};
  int b_e  [6] = '{0, 0, 0, 0, 1, 1};
  int c_e  [6] = '{0, 1, 1, 1, 1, 1};
  int d_cnt[6] = '{1, 2, 3, 3, 3, 3};

  pc_sequencer u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt), .ext_halt_i(halt),
    .pc_o(pc_a), .pc_plus_o(pcp_a), .pc_valid_o(v_a), .eof_o(e_a),
    .fault_o(f_a), .retired_count_o(cnt_a)
  );

  pc_sequencer #(.PROG_WORDS(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt), .ext_halt_i(halt),
    .pc_o(pc_b), .pc_plus_o(pcp_b), .pc_valid_o(v_b), .eof_o(e_b),
    .fault_o(f_b), .retired_count_o(cnt_b)
  );

  pc_sequencer #(.PROG_WORDS(1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt), .ext_halt_i(halt),
    .pc_o(pc_c), .pc_plus_o(pcp_c), .pc_valid_o(v_c), .eof_o(e_c),
    .fault_o(f_c), .retired_count_o(cnt_c)
  );

  pc_sequencer #(.CNT_W(2)) u_dut_d (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_taken_i(br),
    .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt), .ext_halt_i(halt),
    .pc_o(pc_d), .pc_plus_o(pcp_d), .pc_valid_o(v_d), .eof_o(e_d),
    .fault_o(f_d), .retired_count_o(cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rn, input bit st, input bit b, input logic [31:0] btg,
                     input bit j, input logic [31:0] jtg, input bit h,
                     input logic [31:0] epc, input bit ev, input bit ee, input bit ef,
                     input logic [31:0] ec);
    vec_t v;
    v.rst_n = rn; v.stall = st; v.br = b; v.bt = btg; v.jmp = j; v.jt = jtg; v.halt = h;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_eof = ee; v.exp_fault = ef; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic drive(input bit rn, input bit st, input bit b, input logic [31:0] btg,
                       input bit j, input logic [31:0] jtg, input bit h);
    rst_n = rn; stall = st; br = b; bt = btg; jmp = j; jt = jtg; halt = h;
  endtask

  initial begin
    //   rst st br bt     jmp jt     halt  pc      v  e  f  cnt
    // Reset then free run
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   1, 0, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h8,   1, 0, 0, 2);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'hC,   1, 0, 0, 3);
    // Jump beats branch, stall holds, branch alone
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   1, 0, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h8,   1, 0, 0, 2);
    add(1, 0, 1, 32'h20, 1, 32'h40,  0,   32'h40,  1, 0, 0, 3);
    add(1, 1, 0, 32'h0,  0, 32'h0,   0,   32'h40,  1, 0, 0, 3);
    add(1, 0, 1, 32'h80, 0, 32'h0,   0,   32'h80,  1, 0, 0, 4);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h84,  1, 0, 0, 5);
    // ext_halt with stall, then HALT ignores inputs
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   1, 0, 0, 1);
    add(1, 1, 0, 32'h0,  0, 32'h0,   1,   32'h4,   0, 0, 0, 1);
    add(1, 0, 0, 32'h0,  1, 32'h10,  0,   32'h4,   0, 1, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   0, 1, 0, 1);
    // Reset during DRAIN
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   1, 0, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   1,   32'h4,   0, 0, 0, 1);
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    // Misaligned branch -> fault, DRAIN, HALT; reset during HALT clears it
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   1, 0, 0, 1);
    add(1, 0, 1, 32'h22, 0, 32'h0,   0,   32'h4,   0, 0, 1, 2);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h4,   0, 1, 1, 2);
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    // Jump past last valid PC
    add(1, 0, 0, 32'h0,  1, 32'h400, 0,   32'h0,   0, 0, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   0, 1, 0, 1);
    // Jump to last valid PC, then sequential step leaves the program
    add(0, 0, 0, 32'h0,  0, 32'h0,   0,   32'h0,   1, 0, 0, 0);
    add(1, 0, 0, 32'h0,  1, 32'h3FC, 0,   32'h3FC, 1, 0, 0, 1);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h3FC, 0, 0, 0, 2);
    add(1, 0, 0, 32'h0,  0, 32'h0,   0,   32'h3FC, 0, 1, 0, 2);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst_n, vq[i].stall, vq[i].br, vq[i].bt, vq[i].jmp, vq[i].jt, vq[i].halt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i),      pc_a,         vq[i].exp_pc);
      check($sformatf("v%0d pc_plus", i), pcp_a,        vq[i].exp_pc + 32'd4);
      check($sformatf("v%0d valid", i),   32'(v_a),     32'(vq[i].exp_valid));
      check($sformatf("v%0d eof", i),     32'(e_a),     32'(vq[i].exp_eof));
      check($sformatf("v%0d fault", i),   32'(f_a),     32'(vq[i].exp_fault));
      check($sformatf("v%0d count", i),   cnt_a,        vq[i].exp_cnt);
    end

    // Four-word program, one-word program and 2-bit saturating counter
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    check("b reset pc", pc_b, 32'h0);
    check("c reset valid", 32'(v_c), 32'd1);
    check("d reset count", 32'(cnt_d), 32'd0);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b%0d pc", k),    pc_b,          32'(b_pc[k]));
      check($sformatf("b%0d count", k), cnt_b,         32'(b_cnt[k]));
      check($sformatf("b%0d valid", k), 32'(v_b),      32'(b_v[k]));
      check($sformatf("b%0d eof", k),   32'(e_b),      32'(b_e[k]));
      check($sformatf("c%0d pc", k),    pc_c,          32'h0);
      check($sformatf("c%0d count", k), cnt_c,         32'd1);
      check($sformatf("c%0d valid", k), 32'(v_c),      32'd0);
      check($sformatf("c%0d eof", k),   32'(e_c),      32'(c_e[k]));
      check($sformatf("d%0d count", k), 32'(cnt_d),    32'(d_cnt[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
